// File: rtl/xprs_pkg.sv
// Shared definitions for the register-file context save/restore engine:
// default data width, register address width and the FSM state encoding.
package xprs_pkg;

    localparam int XPRS_XLEN   = 64;
    localparam int XPRS_REG_AW = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_RESTORE = 2'd3
    } xprs_state_e;

endpackage

// File: rtl/xprs_ctx.sv
// Context save/restore engine driving the integer register file (2R1W, x0 = 0).
// Optional macro XPRS_CTX_CHKSUM_EN adds chksum_o, the XOR of all transferred words.
module xprs_ctx
    import xprs_pkg::*;
#(
    parameter int XLEN      = XPRS_XLEN,
    parameter int FIRST_REG = 1,
    parameter int LAST_REG  = 31
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   start_save_i,
    input  logic                   start_restore_i,
    input  logic                   abort_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [XPRS_REG_AW-1:0] xrs1_o,
    input  logic [XLEN-1:0]        xq1_i,
    output logic [XPRS_REG_AW-1:0] xrd_o,
    output logic                   xwe_o,
    output logic [XLEN-1:0]        xd_o,
    output logic [XLEN-1:0]        sq_o,
    output logic                   svalid_o,
    input  logic                   sready_i,
    input  logic [XLEN-1:0]        sd_i,
    input  logic                   sdvalid_i,
    output logic                   sdready_o
`ifdef XPRS_CTX_CHKSUM_EN
    ,
    output logic [XLEN-1:0]        chksum_o
`endif
);

    localparam logic [XPRS_REG_AW-1:0] FIRST_IDX = XPRS_REG_AW'(FIRST_REG);
    localparam logic [XPRS_REG_AW-1:0] LAST_IDX  = XPRS_REG_AW'(LAST_REG);

    xprs_state_e            state_q, state_d;
    logic [XPRS_REG_AW-1:0] idx_q, idx_d;
    logic [XLEN-1:0]        sq_q, sq_d;
    logic                   svalid_q, svalid_d;
    logic                   done_q, done_d;
    logic                   save_load;
    logic                   restore_hs;
    logic                   start_any;

    // Abort beats every handshake, so neither the save register nor the write port may fire with it.
    assign start_any  = (state_q == ST_IDLE) && (start_save_i || start_restore_i);
    assign save_load  = (state_q == ST_SAVE) && !abort_i && (!svalid_q || sready_i);
    assign restore_hs = (state_q == ST_RESTORE) && !abort_i && sdvalid_i;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= ST_IDLE;
            idx_q    <= FIRST_IDX;
            sq_q     <= '0;
            svalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sq_q     <= sq_d;
            svalid_q <= svalid_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sq_d     = sq_q;
        svalid_d = svalid_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_save_i) begin
                    state_d = ST_SAVE;
                    idx_d   = FIRST_IDX;
                end else if (start_restore_i) begin
                    state_d = ST_RESTORE;
                    idx_d   = FIRST_IDX;
                end
            end
            ST_SAVE: begin
                if (abort_i) begin
                    state_d  = ST_IDLE;
                    idx_d    = FIRST_IDX;
                    svalid_d = 1'b0;
                end else if (save_load) begin
                    sq_d     = xq1_i;
                    svalid_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort_i) begin
                    state_d  = ST_IDLE;
                    idx_d    = FIRST_IDX;
                    svalid_d = 1'b0;
                end else if (svalid_q && sready_i) begin
                    state_d  = ST_IDLE;
                    idx_d    = FIRST_IDX;
                    svalid_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            ST_RESTORE: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                    idx_d   = FIRST_IDX;
                end else if (restore_hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = FIRST_IDX;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                idx_d    = FIRST_IDX;
                svalid_d = 1'b0;
            end
        endcase
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = done_q;
    assign sq_o      = sq_q;
    assign svalid_o  = svalid_q;
    assign xrs1_o    = (state_q == ST_SAVE) ? idx_q : '0;
    assign xrd_o     = (state_q == ST_RESTORE) ? idx_q : '0;
    assign xd_o      = (state_q == ST_RESTORE) ? sd_i : '0;
    assign xwe_o     = restore_hs;
    assign sdready_o = (state_q == ST_RESTORE);

`ifdef XPRS_CTX_CHKSUM_EN
    logic [XLEN-1:0] chksum_q;

    // Cleared on the start edge, then folds in each word exactly when it is transferred.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            chksum_q <= '0;
        end else if (start_any) begin
            chksum_q <= '0;
        end else if (save_load) begin
            chksum_q <= chksum_q ^ xq1_i;
        end else if (restore_hs) begin
            chksum_q <= chksum_q ^ sd_i;
        end
    end

    assign chksum_o = chksum_q;
`else
    logic unused_start;
    assign unused_start = start_any;
`endif

endmodule

// File: tb/tb_xprs_ctx.sv
// Self-checking bench for xprs_ctx: table of save/restore scenarios run against a
// register-file array and a word-level reference model, plus abort/reset sequences.
module tb_xprs_ctx;

    localparam int XLEN  = 64;
    localparam int FIRST = 1;
    localparam int LAST  = 31;
    localparam int NWORD = LAST - FIRST + 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start_save, start_restore, abort;
    logic            busy, done;
    logic [4:0]      xrs1, xrd;
    logic [XLEN-1:0] xq1, xd, sq, sd;
    logic            xwe, svalid, sready, sdvalid, sdready;
`ifdef XPRS_CTX_CHKSUM_EN
    logic [XLEN-1:0] chksum;
`endif

    int errors = 0;
    int checks = 0;

    logic [XLEN-1:0] rf [32];
    logic [XLEN-1:0] model_rf [32];
    logic [XLEN-1:0] preload_val [32];
    logic            preload_req = 1'b0;

    typedef struct {
        bit do_save;
        bit do_restore;
        int stall_mode;
        int data_mode;
        int abort_after;
        int exp_words;
        bit exp_done;
        int exp_busy;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    xprs_ctx #(.XLEN(XLEN), .FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
        .clk_i           (clk),
        .reset_ni        (reset_n),
        .start_save_i    (start_save),
        .start_restore_i (start_restore),
        .abort_i         (abort),
        .busy_o          (busy),
        .done_o          (done),
        .xrs1_o          (xrs1),
        .xq1_i           (xq1),
        .xrd_o           (xrd),
        .xwe_o           (xwe),
        .xd_o            (xd),
        .sq_o            (sq),
        .svalid_o        (svalid),
        .sready_i        (sready),
        .sd_i            (sd),
        .sdvalid_i       (sdvalid),
        .sdready_o       (sdready)
`ifdef XPRS_CTX_CHKSUM_EN
        ,
        .chksum_o        (chksum)
`endif
    );

    // Environment register file: async read, x0 hardwired, rising-edge write.
    always @(posedge clk) begin
        if (preload_req) begin
            for (int r = 0; r < 32; r++) rf[r] <= preload_val[r];
        end else if (xwe && xrd != 5'd0) begin
            rf[xrd] <= xd;
        end
    end
    assign xq1 = (xrs1 == 5'd0) ? '0 : rf[xrs1];

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (xwe && xrd == 5'd0) begin
                errors++;
                $display("[TB] FAIL xwe_x0: got xwe=1 with xrd=0, expected no write to x0");
            end
        end
    end

    task automatic check_output(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_rf(input string name);
        int mism = 0;
        for (int r = 0; r < 32; r++) begin
            if (rf[r] !== model_rf[r]) begin
                mism++;
                $display("[TB] %s: x%0d holds %h, model %h", name, r, rf[r], model_rf[r]);
            end
        end
        check_output(name, XLEN'(mism), '0);
    endtask

    task automatic preload_rf();
        for (int r = 0; r < 32; r++) begin
            model_rf[r]    = (r == 0 || r == 31) ? '0 : XLEN'(r) * 64'h1111111111111111;
            preload_val[r] = model_rf[r];
        end
        @(negedge clk);
        preload_req = 1'b1;
        @(negedge clk);
        preload_req = 1'b0;
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic run_save(input vec_t v, input int vi);
        logic [XLEN-1:0] expq [$];
        logic [XLEN-1:0] xacc = '0;
        logic [XLEN-1:0] prev_sq = '0;
        logic            prev_stall = 1'b0;
        int got = 0, busy_cycles = 0, cyc = 0;
        for (int r = FIRST; r <= LAST; r++) expq.push_back(model_rf[r]);
        @(negedge clk);
        start_save    = 1'b1;
        start_restore = v.do_restore;
        @(negedge clk);
        start_save    = 1'b0;
        start_restore = 1'b0;
        while (busy) begin
            busy_cycles++;
            if (cyc == 0) check_output($sformatf("v%0d_first_xrs1", vi), XLEN'(xrs1), XLEN'(FIRST));
            if (prev_stall) begin
                check_output($sformatf("v%0d_hold_valid", vi), XLEN'(svalid), 1);
                check_output($sformatf("v%0d_hold_sq", vi), sq, prev_sq);
            end
            check_output($sformatf("v%0d_save_xwe", vi), XLEN'(xwe), 0);
            sready = pick_ready(v.stall_mode, cyc);
            start_save    = v.do_restore && (cyc == 10);
            start_restore = v.do_restore && (cyc == 10);
            if (svalid && sready) begin
                if (expq.size() > 0) begin
                    check_output($sformatf("v%0d_word%0d", vi, got), sq, expq.pop_front());
                end else begin
                    check_output($sformatf("v%0d_extra_word", vi), XLEN'(got), XLEN'(NWORD - 1));
                end
                xacc ^= sq;
                got++;
            end
            prev_stall = svalid && !sready;
            prev_sq    = sq;
            cyc++;
            if (cyc > 400) begin
                check_output($sformatf("v%0d_save_timeout", vi), 1, 0);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start_save    = 1'b0;
        start_restore = 1'b0;
        check_output($sformatf("v%0d_done", vi), XLEN'(done), XLEN'(v.exp_done));
        check_output($sformatf("v%0d_words", vi), XLEN'(got), XLEN'(v.exp_words));
        if (v.exp_busy >= 0) check_output($sformatf("v%0d_busy_cycles", vi), XLEN'(busy_cycles), XLEN'(v.exp_busy));
`ifdef XPRS_CTX_CHKSUM_EN
        check_output($sformatf("v%0d_chksum", vi), chksum, xacc);
`endif
        sready = 1'b0;
        compare_rf($sformatf("v%0d_rf_after_save", vi));
    endtask

    task automatic run_restore(input vec_t v, input int vi);
        logic [XLEN-1:0] data [NWORD];
        logic [XLEN-1:0] xacc = '0;
        int acc = 0, cyc = 0;
        for (int k = 0; k < NWORD; k++) begin
            data[k] = (v.data_mode == 0) ? (64'hDEADBEEFFEEDFACE ^ XLEN'(FIRST + k)) : {$urandom, $urandom};
        end
        @(negedge clk);
        start_restore = 1'b1;
        @(negedge clk);
        start_restore = 1'b0;
        while (busy) begin
            if (cyc < 3) check_output($sformatf("v%0d_sdready", vi), XLEN'(sdready), 1);
            abort   = (v.abort_after >= 0) && (acc == v.abort_after);
            sdvalid = abort || pick_ready(v.stall_mode, cyc);
            sd      = (acc < NWORD) ? data[acc] : {$urandom, $urandom};
            #1;
            check_output($sformatf("v%0d_xwe_c%0d", vi, cyc), XLEN'(xwe), XLEN'(sdvalid && !abort));
            if (sdvalid && !abort) begin
                check_output($sformatf("v%0d_xrd%0d", vi, acc), XLEN'(xrd), XLEN'(FIRST + acc));
                model_rf[FIRST + acc] = sd;
                xacc ^= sd;
                acc++;
            end
            cyc++;
            if (cyc > 400) begin
                check_output($sformatf("v%0d_restore_timeout", vi), 1, 0);
                abort = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        abort   = 1'b0;
        sdvalid = 1'b0;
        check_output($sformatf("v%0d_done", vi), XLEN'(done), XLEN'(v.exp_done));
        check_output($sformatf("v%0d_words", vi), XLEN'(acc), XLEN'(v.exp_words));
        check_output($sformatf("v%0d_idle_sdready", vi), XLEN'(sdready), 0);
`ifdef XPRS_CTX_CHKSUM_EN
        check_output($sformatf("v%0d_chksum", vi), chksum, xacc);
`endif
        compare_rf($sformatf("v%0d_rf_after_restore", vi));
    endtask

    task automatic apply_stimulus(input vec_t v, input int vi);
        if (v.do_save) run_save(v, vi);
        else           run_restore(v, vi);
    endtask

    initial begin
        reset_n       = 1'b0;
        start_save    = 1'b0;
        start_restore = 1'b0;
        abort         = 1'b0;
        sready        = 1'b0;
        sdvalid       = 1'b0;
        sd            = '0;

        //          save restore stall data abort words done busy
        vecs[0] = '{1'b1, 1'b0, 0, 0, -1, 31, 1'b1, 32};
        vecs[1] = '{1'b1, 1'b0, 1, 0, -1, 31, 1'b1, -1};
        vecs[2] = '{1'b0, 1'b1, 2, 0, -1, 31, 1'b1, -1};
        vecs[3] = '{1'b1, 1'b1, 2, 0, -1, 31, 1'b1, -1};
        vecs[4] = '{1'b0, 1'b1, 2, 1,  5,  5, 1'b0, -1};
        vecs[5] = '{1'b1, 1'b0, 2, 0, -1, 31, 1'b1, -1};
        vecs[6] = '{1'b0, 1'b1, 2, 1, -1, 31, 1'b1, -1};
        vecs[7] = '{1'b1, 1'b0, 0, 0, -1, 31, 1'b1, 32};

        repeat (3) @(negedge clk);
        check_output("rst_busy",    XLEN'(busy),    0);
        check_output("rst_done",    XLEN'(done),    0);
        check_output("rst_svalid",  XLEN'(svalid),  0);
        check_output("rst_sq",      sq,             0);
        check_output("rst_xrs1",    XLEN'(xrs1),    0);
        check_output("rst_xrd",     XLEN'(xrd),     0);
        check_output("rst_xwe",     XLEN'(xwe),     0);
        check_output("rst_sdready", XLEN'(sdready), 0);
        reset_n = 1'b1;

        preload_rf();
        for (int i = 0; i < 8; i++) apply_stimulus(vecs[i], i);

        // Abort mid-save: idle on the next edge, stream invalidated, no completion pulse.
        preload_rf();
        @(negedge clk);
        start_save = 1'b1;
        @(negedge clk);
        start_save = 1'b0;
        sready     = 1'b1;
        repeat (4) @(negedge clk);
        sready = 1'b0;
        abort  = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_save_busy",   XLEN'(busy),   0);
        check_output("abort_save_svalid", XLEN'(svalid), 0);
        check_output("abort_save_done",   XLEN'(done),   0);
        @(negedge clk);
        check_output("abort_save_done2",  XLEN'(done),   0);

        // Reset mid-save takes effect without waiting for a clock edge.
        start_save = 1'b1;
        @(negedge clk);
        start_save = 1'b0;
        sready     = 1'b1;
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_output("rstmid_save_svalid", XLEN'(svalid), 0);
        check_output("rstmid_save_busy",   XLEN'(busy),   0);
        check_output("rstmid_save_sq",     sq,            0);
        @(negedge clk);
        reset_n = 1'b1;
        sready  = 1'b0;

        // Reset mid-restore: three words land, the fourth is blocked by reset.
        @(negedge clk);
        start_restore = 1'b1;
        @(negedge clk);
        start_restore = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sdvalid = 1'b1;
            sd      = {$urandom, $urandom};
            model_rf[FIRST + k] = sd;
            @(negedge clk);
        end
        sd = {$urandom, $urandom};
        #2 reset_n = 1'b0;
        #1;
        check_output("rstmid_restore_xwe",  XLEN'(xwe),  0);
        check_output("rstmid_restore_busy", XLEN'(busy), 0);
        @(negedge clk);
        sdvalid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        compare_rf("rstmid_restore_rf");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
